// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds the bubble instruction, the boot PC and the IF/ID field widths so the
// fetch, decode and hazard logic all agree on the same constants.
// No ports: package only.
package mips_pkg;

  localparam int XLEN           = 32;
  localparam int IFID_INSTR_W   = 32;
  localparam int IFID_PC_W      = 32;

  // sll $0,$0,0 encodes as all zeros.
  localparam logic [IFID_INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0]         RESET_PC  = 32'h0000_0000;

  // What the IF/ID register does on the next edge.
  typedef enum logic [1:0] {
    IFID_CAPTURE = 2'd0,  // take the fetched instruction and PC+4
    IFID_HOLD    = 2'd1,  // keep every field
    IFID_BUBBLE  = 2'd2   // insert a NOP, clear valid, keep PC+4
  } ifid_op_e;

  // Sequential PC step; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instr_mem.
// Signals:
//   addr_imem_ram_o        fetch -> imem  byte address (fetch PC or load address)
//   wr_instr_imem_ram_o    fetch -> imem  boot-load write data
//   wr_en_imem_ram_o       fetch -> imem  boot-load write enable
//   read_instr_imem_ram_i  imem -> fetch  combinational read of addr_imem_ram_o
interface fetch_stage_if;

  logic [31:0] addr_imem_ram_o;
  logic [31:0] wr_instr_imem_ram_o;
  logic        wr_en_imem_ram_o;
  logic [31:0] read_instr_imem_ram_i;

  modport master (
    output addr_imem_ram_o,
    output wr_instr_imem_ram_o,
    output wr_en_imem_ram_o,
    input  read_instr_imem_ram_i
  );

  modport slave (
    input  addr_imem_ram_o,
    input  wr_instr_imem_ram_o,
    input  wr_en_imem_ram_o,
    output read_instr_imem_ram_i
  );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   op              capture / hold / bubble for this edge
//   fetched_instr   instruction returned by instr_mem
//   fetched_pc4     PC+4 of the instruction being fetched
//   instr, pc_plus4, valid   registered IF/ID fields
module ifid_reg
  import mips_pkg::*;
#(
  parameter logic [IFID_INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  ifid_op_e                op,
  input  logic [IFID_INSTR_W-1:0] fetched_instr,
  input  logic [IFID_PC_W-1:0]    fetched_pc4,
  output logic [IFID_INSTR_W-1:0] instr,
  output logic [IFID_PC_W-1:0]    pc_plus4,
  output logic                    valid
);

  logic [IFID_INSTR_W-1:0] instr_reg;
  logic [IFID_PC_W-1:0]    pc_plus4_reg;
  logic                    valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg    <= BUBBLE_INSTR;
      pc_plus4_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      case (op)
        IFID_CAPTURE: begin
          instr_reg    <= fetched_instr;
          pc_plus4_reg <= fetched_pc4;
          valid_reg    <= 1'b1;
        end
        // A bubble leaves PC+4 untouched; only the instruction and valid matter.
        IFID_BUBBLE: begin
          instr_reg <= BUBBLE_INSTR;
          valid_reg <= 1'b0;
        end
        default: ;  // hold
      endcase
    end
  end

  assign instr    = instr_reg;
  assign pc_plus4 = pc_plus4_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC selection, instr_mem addressing,
// boot-load write path and the IF/ID pipeline register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall_fetch_i              hold PC and IF/ID
//   redirect_i, redirect_pc_i  taken branch/jump and its target
//   load_en_i                  boot-load mode (fetch frozen, PC parked at RESET_PC)
//   load_addr_i, load_instr_i, load_wr_i   boot-load word, address and strobe
//   imem                       instr_mem bus (master side)
//   pc_o                       current PC
//   ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o   IF/ID register contents
//   misalign_o                 one-cycle pulse for a redirect target with [1:0] != 0
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_fetch_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  input  logic                 load_en_i,
  input  logic [31:0]          load_addr_i,
  input  logic [31:0]          load_instr_i,
  input  logic                 load_wr_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          pc_o,
  output logic [31:0]          ifid_instr_o,
  output logic [31:0]          ifid_pc_plus4_o,
  output logic                 ifid_valid_o,
  output logic                 misalign_o
);

  import mips_pkg::*;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        misalign_reg;
  logic        misalign_next;
  ifid_op_e    ifid_op;

  assign pc_plus4 = pc_step(pc_reg);

  // The write enable is gated by rst_n so a load word presented while reset
  // is asserted never reaches memory.
  assign imem.addr_imem_ram_o     = load_en_i ? load_addr_i : pc_reg;
  assign imem.wr_instr_imem_ram_o = load_instr_i;
  assign imem.wr_en_imem_ram_o    = load_en_i & load_wr_i & rst_n;

  // Priority: load > redirect > stall > sequential fetch.
  always_comb begin
    pc_next       = pc_plus4;
    ifid_op       = IFID_CAPTURE;
    misalign_next = 1'b0;
    if (load_en_i) begin
      pc_next = RESET_PC;
      ifid_op = IFID_BUBBLE;
    end else if (redirect_i) begin
      // The instruction fetched this cycle is on the wrong path, so flush it.
      pc_next       = {redirect_pc_i[31:2], 2'b00};
      ifid_op       = IFID_BUBBLE;
      misalign_next = |redirect_pc_i[1:0];
    end else if (stall_fetch_i) begin
      pc_next = pc_reg;
      ifid_op = IFID_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      misalign_reg <= misalign_next;
    end
  end

  ifid_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (ifid_op),
    .fetched_instr (imem.read_instr_imem_ram_i),
    .fetched_pc4   (pc_plus4),
    .instr         (ifid_instr_o),
    .pc_plus4      (ifid_pc_plus4_o),
    .valid         (ifid_valid_o)
  );

  assign pc_o       = pc_reg;
  assign misalign_o = misalign_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a 64-word instr_mem model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_fetch_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        load_en_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_instr_i;
  logic        load_wr_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_plus4_o;
  logic        ifid_valid_o;
  logic        misalign_o;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_fetch_i   (stall_fetch_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .load_en_i       (load_en_i),
    .load_addr_i     (load_addr_i),
    .load_instr_i    (load_instr_i),
    .load_wr_i       (load_wr_i),
    .imem            (imem.master),
    .pc_o            (pc_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc_plus4_o (ifid_pc_plus4_o),
    .ifid_valid_o    (ifid_valid_o),
    .misalign_o      (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instr_mem model: combinational read, write on the rising edge.
  logic [31:0] mem [64];
  assign imem.read_instr_imem_ram_i = mem[imem.addr_imem_ram_o[7:2]];
  always @(posedge clk) begin
    if (imem.wr_en_imem_ram_o) mem[imem.addr_imem_ram_o[7:2]] = imem.wr_instr_imem_ram_o;
  end

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ld;
    logic [31:0] laddr;
    logic [31:0] linstr;
    logic        lwr;
    logic [31:0] e_addr;   // imem address before the edge
    logic        e_wr;     // imem write enable before the edge
    logic [31:0] e_pc;     // after the edge
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic st, input logic rd, input logic [31:0] rpc,
    input logic ld, input logic [31:0] la, input logic [31:0] li, input logic lw,
    input logic [31:0] ea, input logic ew,
    input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] e4,
    input logic ev, input logic em);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.ld = ld; v.laddr = la;
    v.linstr = li; v.lwr = lw; v.e_addr = ea; v.e_wr = ew; v.e_pc = ep;
    v.e_instr = ei; v.e_pc4 = e4; v.e_valid = ev; v.e_mis = em;
    return v;
  endfunction

  task automatic idle_inputs();
    stall_fetch_i = 0; redirect_i = 0; redirect_pc_i = 0;
    load_en_i = 0; load_addr_i = 0; load_instr_i = 0; load_wr_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | i;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0001 + i;
    mem[16] = 32'h2000_0040;
    mem[17] = 32'h2000_0044;
    mem[63] = 32'h3000_00FC;

    //          st rd rpc           ld laddr  linstr        lw  addr         wr  pc           instr         pc4          v  mis
    // Sequential fetch.
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'h0,       0, 32'h4,       32'h1000_0001, 32'h4,       1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'h4,       0, 32'h8,       32'h1000_0002, 32'h8,       1, 0));
    // Three-cycle stall at pc=8.
    vecs.push_back(mk(1, 0, 0,            0, 0,     0,            0, 32'h8,       0, 32'h8,       32'h1000_0002, 32'h8,       1, 0));
    vecs.push_back(mk(1, 0, 0,            0, 0,     0,            0, 32'h8,       0, 32'h8,       32'h1000_0002, 32'h8,       1, 0));
    vecs.push_back(mk(1, 0, 0,            0, 0,     0,            0, 32'h8,       0, 32'h8,       32'h1000_0002, 32'h8,       1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'h8,       0, 32'hC,       32'h1000_0003, 32'hC,       1, 0));
    // Redirect to 0x40 at pc=C: bubble, then imem[0x40].
    vecs.push_back(mk(0, 1, 32'h40,       0, 0,     0,            0, 32'hC,       0, 32'h40,      32'h0,         32'hC,       0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'h40,      0, 32'h44,      32'h2000_0040, 32'h44,      1, 0));
    // Redirect + stall with misaligned target 0x42.
    vecs.push_back(mk(1, 1, 32'h42,       0, 0,     0,            0, 32'h44,      0, 32'h40,      32'h0,         32'h44,      0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'h40,      0, 32'h44,      32'h2000_0040, 32'h44,      1, 0));
    // Wrap: redirect to 0xFFFF_FFFC, next pc is 0.
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,0, 0,     0,            0, 32'h44,      0, 32'hFFFF_FFFC,32'h0,        32'h44,      0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'hFFFF_FFFC,0,32'h0,       32'h3000_00FC, 32'h0,       1, 0));
    // Boot-load of four words with a strobe gap.
    vecs.push_back(mk(0, 0, 0,            1, 32'h0, 32'hAAAA_0000,1, 32'h0,       1, 32'h0,       32'h0,         32'h0,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h4, 32'h5555_5555,0, 32'h4,       0, 32'h0,       32'h0,         32'h0,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h4, 32'hAAAA_0001,1, 32'h4,       1, 32'h0,       32'h0,         32'h0,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 32'h8, 32'hAAAA_0002,1, 32'h8,       1, 32'h0,       32'h0,         32'h0,       0, 0));
    vecs.push_back(mk(1, 1, 32'h43,       1, 32'hC, 32'hAAAA_0003,1, 32'hC,       1, 32'h0,       32'h0,         32'h0,       0, 0));
    // Load exit: fetch restarts at RESET_PC with the loaded words.
    vecs.push_back(mk(0, 0, 0,            0, 32'hC, 32'hAAAA_0003,1, 32'h0,       0, 32'h4,       32'hAAAA_0000, 32'h4,       1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'h4,       0, 32'h8,       32'hAAAA_0001, 32'h8,       1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'h8,       0, 32'hC,       32'hAAAA_0002, 32'hC,       1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0,     0,            0, 32'hC,       0, 32'h10,      32'hAAAA_0003, 32'h10,      1, 0));

    // Reset state.
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", ifid_instr_o, 32'h0);
    chk("rst_pc4", ifid_pc_plus4_o, 32'h0);
    chk("rst_valid", ifid_valid_o, 1'b0);
    chk("rst_mis", misalign_o, 1'b0);
    $display("[TB] reset pc=%h instr=%h valid=%b", pc_o, ifid_instr_o, ifid_valid_o);

    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      stall_fetch_i = vecs[i].stall; redirect_i = vecs[i].redir; redirect_pc_i = vecs[i].rpc;
      load_en_i = vecs[i].ld; load_addr_i = vecs[i].laddr;
      load_instr_i = vecs[i].linstr; load_wr_i = vecs[i].lwr;
      #1;
      chk($sformatf("v%0d_addr", i), imem.addr_imem_ram_o, vecs[i].e_addr);
      chk($sformatf("v%0d_wren", i), imem.wr_en_imem_ram_o, vecs[i].e_wr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), ifid_instr_o, vecs[i].e_instr);
      chk($sformatf("v%0d_pc4", i), ifid_pc_plus4_o, vecs[i].e_pc4);
      chk($sformatf("v%0d_valid", i), ifid_valid_o, vecs[i].e_valid);
      chk($sformatf("v%0d_mis", i), misalign_o, vecs[i].e_mis);
      $display("[TB] vec %0d pc=%h instr=%h pc4=%h valid=%b mis=%b", i, pc_o,
               ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o, misalign_o);
      @(negedge clk);
    end

    // Asynchronous reset mid-stall while a load write is presented.
    stall_fetch_i = 1;
    @(posedge clk);
    #1;
    chk("stall_pc", pc_o, 32'h10);
    #1;
    load_en_i = 1; load_wr_i = 1; load_addr_i = 32'h8; load_instr_i = 32'hBAD0_0000;
    #1;
    chk("pre_rst_wren", imem.wr_en_imem_ram_o, 1'b1);
    rst_n = 0;
    #1;
    chk("arst_wren", imem.wr_en_imem_ram_o, 1'b0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_instr", ifid_instr_o, 32'h0);
    chk("arst_pc4", ifid_pc_plus4_o, 32'h0);
    chk("arst_valid", ifid_valid_o, 1'b0);
    $display("[TB] async reset mid-stall pc=%h valid=%b wr_en=%b", pc_o, ifid_valid_o,
             imem.wr_en_imem_ram_o);
    @(posedge clk);
    #1;
    chk("arst_nowrite", mem[2], 32'hAAAA_0002);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rel_pc", pc_o, 32'h4);
    chk("rel_instr", ifid_instr_o, 32'hAAAA_0000);
    $display("[TB] reset release pc=%h instr=%h", pc_o, ifid_instr_o);

    // Misalign pulse cleared asynchronously by reset.
    @(negedge clk);
    redirect_i = 1; redirect_pc_i = 32'h41;
    @(posedge clk);
    #1;
    chk("mis_pc", pc_o, 32'h40);
    chk("mis_set", misalign_o, 1'b1);
    #1;
    rst_n = 0;
    #1;
    chk("mis_arst", misalign_o, 1'b0);
    $display("[TB] misalign async clear mis=%b pc=%h", misalign_o, pc_o);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
